// File: rtl/shifter_operand_pipe.sv
// Pipelined ARM shifter-operand unit: derives val2 and the shifter carry-out for
// data-processing and load/store addressing modes, with valid/ready flow control.
module shifter_operand_pipe #(
   parameter int unsigned PIPE_STAGES = 1,
   parameter int unsigned TAG_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       val_rm,
   input  logic [7:0]        val_rs,
   input  logic              imm,
   input  logic [11:0]       shift_operand,
   input  logic              mem_r_en,
   input  logic              mem_w_en,
   input  logic              c_in,
   input  logic [TAG_W-1:0]  tag_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       val2,
   output logic              shifter_carry,
   output logic [TAG_W-1:0]  tag_out
);

   localparam int unsigned DATA_W = 32;

   typedef enum logic [2:0] {
      SK_LSL = 3'd0,
      SK_LSR = 3'd1,
      SK_ASR = 3'd2,
      SK_ROR = 3'd3,
      SK_RRX = 3'd4
   } shift_kind_e;

   // Every addressing mode is normalised to one shift of one operand.
   typedef struct packed {
      logic [DATA_W-1:0] operand;
      shift_kind_e       kind;
      logic [7:0]        amount;
      logic              c_in;
   } shift_op_t;

   typedef struct packed {
      logic [DATA_W-1:0] value;
      logic              carry;
   } shift_res_t;

   function automatic shift_kind_e type_kind(input logic [1:0] t);
      shift_kind_e k;
      case (t)
         2'b00:   k = SK_LSL;
         2'b01:   k = SK_LSR;
         2'b10:   k = SK_ASR;
         default: k = SK_ROR;
      endcase
      return k;
   endfunction

   // Mode priority: load/store offset, rotated immediate, register shift, immediate shift.
   function automatic shift_op_t decode_op(
      input logic [DATA_W-1:0] rm,
      input logic [7:0]        rs,
      input logic              is_imm,
      input logic [11:0]       so,
      input logic              is_mem,
      input logic              c
   );
      shift_op_t   d;
      shift_kind_e k;
      logic [4:0]  n;
      d.operand = rm;
      d.kind    = SK_LSL;
      d.amount  = 8'd0;
      d.c_in    = c;
      k         = type_kind(so[6:5]);
      n         = so[11:7];
      if (is_mem) begin
         d.operand = {20'd0, so};
      end else if (is_imm) begin
         d.operand = {24'd0, so[7:0]};
         d.kind    = SK_ROR;
         d.amount  = {3'd0, so[11:8], 1'b0};
      end else if (so[4]) begin
         d.kind   = k;
         d.amount = rs;
      end else begin
         d.kind   = k;
         d.amount = {3'd0, n};
         // A zero immediate amount encodes #32 for LSR/ASR and RRX for ROR.
         if (n == 5'd0) begin
            case (k)
               SK_LSR, SK_ASR: d.amount = 8'd32;
               SK_ROR:         d.kind   = SK_RRX;
               default:        d.amount = 8'd0;
            endcase
         end
      end
      return d;
   endfunction

   function automatic shift_res_t shift_apply(input shift_op_t d);
      shift_res_t        r;
      logic [4:0]        s;
      logic [DATA_W:0]   wide;
      logic [DATA_W-1:0] rot;
      r.value = d.operand;
      r.carry = d.c_in;
      s       = d.amount[4:0];
      wide    = '0;
      rot     = '0;
      if (d.kind == SK_RRX) begin
         r.value = {d.c_in, d.operand[DATA_W-1:1]};
         r.carry = d.operand[0];
      end else if (d.amount != 8'd0) begin
         case (d.kind)
            SK_LSL: begin
               if (d.amount < 8'd32) begin
                  wide    = {1'b0, d.operand} << s;
                  r.value = wide[DATA_W-1:0];
                  r.carry = wide[DATA_W];
               end else begin
                  r.value = '0;
                  r.carry = (d.amount == 8'd32) ? d.operand[0] : 1'b0;
               end
            end
            SK_LSR: begin
               if (d.amount < 8'd32) begin
                  wide    = {d.operand, 1'b0} >> s;
                  r.value = wide[DATA_W:1];
                  r.carry = wide[0];
               end else begin
                  r.value = '0;
                  r.carry = (d.amount == 8'd32) ? d.operand[DATA_W-1] : 1'b0;
               end
            end
            SK_ASR: begin
               if (d.amount < 8'd32) begin
                  wide    = $signed({d.operand, 1'b0}) >>> s;
                  r.value = wide[DATA_W:1];
                  r.carry = wide[0];
               end else begin
                  r.value = {DATA_W{d.operand[DATA_W-1]}};
                  r.carry = d.operand[DATA_W-1];
               end
            end
            SK_ROR: begin
               if (s == 5'd0) begin
                  r.carry = d.operand[DATA_W-1];
               end else begin
                  rot     = DATA_W'({d.operand, d.operand} >> s);
                  r.value = rot;
                  r.carry = rot[DATA_W-1];
               end
            end
            default: begin
               r.value = d.operand;
               r.carry = d.c_in;
            end
         endcase
      end
      return r;
   endfunction

   shift_op_t dec_op;
   logic      out_adv;

   always_comb begin
      dec_op = decode_op(val_rm, val_rs, imm, shift_operand, mem_r_en | mem_w_en, c_in);
   end

   assign out_adv = !out_valid || out_ready;

   if (PIPE_STAGES == 2) begin : g_two_stage
      shift_op_t        s1_op;
      logic [TAG_W-1:0] s1_tag;
      logic             s1_valid;
      logic             s1_adv;
      shift_res_t       s1_res;

      assign s1_adv   = !s1_valid || out_adv;
      assign in_ready = s1_adv && !flush;

      always_comb begin
         s1_res = shift_apply(s1_op);
      end

      // Stage 1: decoded operand, shift kind and effective amount.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_tag   <= '0;
         end else if (flush) begin
            s1_valid <= 1'b0;
         end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_op  <= dec_op;
               s1_tag <= tag_in;
            end
         end
      end

      // Stage 2: shifter result.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            out_valid     <= 1'b0;
            val2          <= '0;
            shifter_carry <= 1'b0;
            tag_out       <= '0;
         end else if (flush) begin
            out_valid <= 1'b0;
         end else if (out_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               val2          <= s1_res.value;
               shifter_carry <= s1_res.carry;
               tag_out       <= s1_tag;
            end
         end
      end
   end else begin : g_one_stage
      shift_res_t in_res;

      assign in_ready = out_adv && !flush;

      always_comb begin
         in_res = shift_apply(dec_op);
      end

      // Decode and shift in one cycle into the output register.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            out_valid     <= 1'b0;
            val2          <= '0;
            shifter_carry <= 1'b0;
            tag_out       <= '0;
         end else if (flush) begin
            out_valid <= 1'b0;
         end else if (out_adv) begin
            out_valid <= in_valid;
            if (in_valid) begin
               val2          <= in_res.value;
               shifter_carry <= in_res.carry;
               tag_out       <= tag_in;
            end
         end
      end
   end

endmodule

// File: tb/tb_shifter_operand_pipe.sv
// Scoreboard bench for shifter_operand_pipe: a two-stage and a one-stage instance
// share stimulus; per-instance monitors pop expected results as outputs transfer.
module tb_shifter_operand_pipe;

   localparam int unsigned TAG_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush;
   logic             in_valid1, in_valid2;
   logic [31:0]      val_rm;
   logic [7:0]       val_rs;
   logic             imm;
   logic [11:0]      shift_operand;
   logic             mem_r_en, mem_w_en;
   logic             c_in;
   logic [TAG_W-1:0] tag_in;
   logic             out_ready;

   logic             in_ready1, out_valid1, carry1;
   logic [31:0]      val2_1;
   logic [TAG_W-1:0] tag1;
   logic             in_ready2, out_valid2, carry2;
   logic [31:0]      val2_2;
   logic [TAG_W-1:0] tag2;

   always #5 clk = ~clk;

   shifter_operand_pipe #(.PIPE_STAGES(2), .TAG_W(TAG_W)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid2), .in_ready(in_ready2),
      .val_rm(val_rm), .val_rs(val_rs), .imm(imm), .shift_operand(shift_operand),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .c_in(c_in), .tag_in(tag_in),
      .out_valid(out_valid2), .out_ready(out_ready),
      .val2(val2_2), .shifter_carry(carry2), .tag_out(tag2)
   );

   shifter_operand_pipe #(.PIPE_STAGES(1), .TAG_W(TAG_W)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .val_rm(val_rm), .val_rs(val_rs), .imm(imm), .shift_operand(shift_operand),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .c_in(c_in), .tag_in(tag_in),
      .out_valid(out_valid1), .out_ready(out_ready),
      .val2(val2_1), .shifter_carry(carry1), .tag_out(tag1)
   );

   typedef struct packed {
      logic [31:0] rm;
      logic [7:0]  rs;
      logic        imm;
      logic [11:0] so;
      logic        mr;
      logic        mw;
      logic        c;
      logic [31:0] ev;
      logic        ec;
      logic [7:0]  tag;
   } vec_t;

   typedef struct {
      logic [31:0] val;
      logic        c;
      logic [7:0]  tag;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic vec_t mk(input logic [31:0] rm, input logic [7:0] rs, input logic im,
                               input logic [11:0] so, input logic mr, input logic mw,
                               input logic c, input logic [31:0] ev, input logic ec);
      vec_t v;
      v.rm = rm; v.rs = rs; v.imm = im; v.so = so; v.mr = mr; v.mw = mw;
      v.c = c; v.ev = ev; v.ec = ec; v.tag = 8'd0;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   task automatic present(input vec_t v, input bit both);
      val_rm = v.rm; val_rs = v.rs; imm = v.imm; shift_operand = v.so;
      mem_r_en = v.mr; mem_w_en = v.mw; c_in = v.c; tag_in = v.tag;
      in_valid2 = 1'b1;
      in_valid1 = both;
   endtask

   // Presents one item, waits (bounded) for acceptance, and records its expectation.
   task automatic send(input vec_t v, input bit both, input bit lat);
      bit   ok;
      exp_t e;
      ok = 1'b0;
      present(v, both);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready2 && (!both || in_ready1)) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout tag=%h in_ready2=%b in_ready1=%b required accept", v.tag, in_ready2, in_ready1);
      end else begin
         e.val = v.ev; e.c = v.ec; e.tag = v.tag; e.acc = cyc + 1; e.lat = lat;
         q2.push_back(e);
         if (both) q1.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      in_valid2 = 1'b0;
   endtask

   // Two-stage monitor: output must match the queue head every cycle it is valid.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid2 === 1'b1) begin
         checks++;
         if (q2.size() == 0) begin
            errors++;
            $display("FAIL out2_unexpected got val2=%h c=%b tag=%h required no item", val2_2, carry2, tag2);
         end else begin
            if (val2_2 !== q2[0].val || carry2 !== q2[0].c || tag2 !== q2[0].tag) begin
               errors++;
               $display("FAIL out2_data got val2=%h c=%b tag=%h required val2=%h c=%b tag=%h",
                        val2_2, carry2, tag2, q2[0].val, q2[0].c, q2[0].tag);
            end
            if (out_ready) begin
               if (q2[0].lat) begin
                  checks++;
                  if (cyc - q2[0].acc != 1) begin
                     errors++;
                     $display("FAIL out2_latency tag=%h got=%0d required=1", q2[0].tag, cyc - q2[0].acc);
                  end
               end
               void'(q2.pop_front());
            end
         end
      end
   end

   // One-stage monitor.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid1 === 1'b1) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL out1_unexpected got val2=%h c=%b tag=%h required no item", val2_1, carry1, tag1);
         end else begin
            if (val2_1 !== q1[0].val || carry1 !== q1[0].c || tag1 !== q1[0].tag) begin
               errors++;
               $display("FAIL out1_data got val2=%h c=%b tag=%h required val2=%h c=%b tag=%h",
                        val2_1, carry1, tag1, q1[0].val, q1[0].c, q1[0].tag);
            end
            if (out_ready) begin
               if (q1[0].lat) begin
                  checks++;
                  if (cyc - q1[0].acc != 0) begin
                     errors++;
                     $display("FAIL out1_latency tag=%h got=%0d required=0", q1[0].tag, cyc - q1[0].acc);
                  end
               end
               void'(q1.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      rst_n = 1'b0; flush = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
      val_rm = '0; val_rs = '0; imm = 1'b0; shift_operand = '0;
      mem_r_en = 1'b0; mem_w_en = 1'b0; c_in = 1'b0; tag_in = '0; out_ready = 1'b1;

      vecs.push_back(mk(32'h0,        8'd0,  1, 12'h4FF, 0, 0, 0, 32'hFF000000, 1));
      vecs.push_back(mk(32'h0,        8'd0,  1, 12'h0FF, 0, 0, 1, 32'h000000FF, 1));
      vecs.push_back(mk(32'h80000001, 8'd0,  0, 12'h020, 0, 0, 0, 32'h00000000, 1));
      vecs.push_back(mk(32'h00000003, 8'd0,  0, 12'h060, 0, 0, 1, 32'h80000001, 1));
      vecs.push_back(mk(32'h80000000, 8'd40, 0, 12'h050, 0, 0, 0, 32'hFFFFFFFF, 1));
      vecs.push_back(mk(32'h80000000, 8'd33, 0, 12'h010, 0, 0, 1, 32'h00000000, 0));
      vecs.push_back(mk(32'h00000001, 8'd32, 0, 12'h010, 0, 0, 0, 32'h00000000, 1));
      vecs.push_back(mk(32'h12345678, 8'd0,  1, 12'hFFF, 1, 0, 1, 32'h00000FFF, 1));
      vecs.push_back(mk(32'h12345678, 8'd0,  0, 12'h800, 0, 1, 0, 32'h00000800, 0));
      vecs.push_back(mk(32'hF0000001, 8'd0,  0, 12'h200, 0, 0, 0, 32'h00000010, 1));
      vecs.push_back(mk(32'h7FFFFFFF, 8'd0,  0, 12'h040, 0, 0, 1, 32'h00000000, 0));
      vecs.push_back(mk(32'h12345678, 8'd0,  0, 12'h460, 0, 0, 1, 32'h78123456, 0));
      vecs.push_back(mk(32'h80000001, 8'd32, 0, 12'h070, 0, 0, 0, 32'h80000001, 1));
      vecs.push_back(mk(32'hDEADBEEF, 8'd0,  0, 12'h030, 0, 0, 1, 32'hDEADBEEF, 1));
      vecs.push_back(mk(32'h0000000F, 8'd4,  0, 12'h030, 0, 0, 0, 32'h00000000, 1));
      vecs.push_back(mk(32'h0000000F, 8'd36, 0, 12'h070, 0, 0, 0, 32'hF0000000, 1));
      vecs.push_back(mk(32'h12345678, 8'd0,  0, 12'h000, 0, 0, 1, 32'h12345678, 1));
      vecs.push_back(mk(32'h0,        8'd0,  1, 12'h101, 0, 0, 1, 32'h40000000, 0));
      vecs.push_back(mk(32'h80000001, 8'd0,  0, 12'h0C0, 0, 0, 0, 32'hC0000000, 1));
      vecs.push_back(mk(32'h80000000, 8'd32, 0, 12'h030, 0, 0, 0, 32'h00000000, 1));
      vecs.push_back(mk(32'h80000000, 8'd33, 0, 12'h030, 0, 0, 1, 32'h00000000, 0));
      vecs.push_back(mk(32'h80000010, 8'd4,  0, 12'h050, 0, 0, 1, 32'hF8000001, 0));
      vecs.push_back(mk(32'h80000001, 8'd1,  0, 12'h010, 0, 0, 0, 32'h00000002, 1));

      // Reset values.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid2", 32'(out_valid2), 32'h0);
      chk("rst_val2_2",     val2_2,          32'h0);
      chk("rst_carry2",     32'(carry2),     32'h0);
      chk("rst_tag2",       32'(tag2),       32'h0);
      chk("rst_out_valid1", 32'(out_valid1), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors, back-to-back, both instances, latency checked.
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         v.tag = 8'(i + 1);
         send(v, 1'b1, 1'b1);
      end
      repeat (4) @(posedge clk);
      #1;
      chk("drain_q2", 32'(q2.size()), 32'h0);
      chk("drain_q1", 32'(q1.size()), 32'h0);

      // Backpressure on the two-stage instance.
      out_ready = 1'b0;
      v = vecs[0];  v.tag = 8'h81; send(v, 1'b0, 1'b0);
      v = vecs[3];  v.tag = 8'h82; send(v, 1'b0, 1'b0);
      v = vecs[4];  v.tag = 8'h83; present(v, 1'b0);
      in_valid1 = 1'b0;
      @(negedge clk);
      chk("bp_in_ready_full", 32'(in_ready2), 32'h0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(v, 1'b0, 1'b0);
      v = vecs[11]; v.tag = 8'h84; send(v, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      chk("bp_drain_q2", 32'(q2.size()), 32'h0);

      // Flush with two items in flight and an input offered.
      out_ready = 1'b0;
      v = vecs[1];  v.tag = 8'h91; send(v, 1'b0, 1'b0);
      v = vecs[2];  v.tag = 8'h92; send(v, 1'b0, 1'b0);
      v = vecs[5];  v.tag = 8'h93; present(v, 1'b1);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready2", 32'(in_ready2), 32'h0);
      chk("flush_in_ready1", 32'(in_ready1), 32'h0);
      @(posedge clk);
      #1;
      chk("flush_out_valid2", 32'(out_valid2), 32'h0);
      chk("flush_out_valid1", 32'(out_valid1), 32'h0);
      q2.delete();
      q1.delete();
      flush = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("post_flush_out_valid2", 32'(out_valid2), 32'h0);

      // Asynchronous reset mid-stream.
      out_ready = 1'b0;
      v = vecs[4];  v.tag = 8'hA1; send(v, 1'b1, 1'b0);
      v = vecs[12]; v.tag = 8'hA2; send(v, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid2", 32'(out_valid2), 32'h0);
      chk("arst_val2_2",     val2_2,          32'h0);
      chk("arst_carry2",     32'(carry2),     32'h0);
      chk("arst_tag2",       32'(tag2),       32'h0);
      chk("arst_out_valid1", 32'(out_valid1), 32'h0);
      chk("arst_val2_1",     val2_1,          32'h0);
      q2.delete();
      q1.delete();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      v = vecs[10]; v.tag = 8'hB1; send(v, 1'b1, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      chk("final_q2", 32'(q2.size()), 32'h0);
      chk("final_q1", 32'(q1.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
